avl_burst_master_tg: RTL

- Avalon-MM burst master traffic generator/checker driving the avs_s1 slave port of the SDRAM controller top, i.e. the initiator end of that interface.
- On start it writes cfg_nbursts fixed-length bursts of a deterministic pattern from cfg_base_addr, then reads every burst back and compares.
- Reports pass/fail, a saturating error count and the first failing address.
- Used for board bring-up and for the regression bench.

---
 rtl/avl_burst_master_tg.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/avl_burst_master_tg.sv
// avl_burst_master_tg: Avalon-MM burst traffic generator that writes a counting
// pattern in fixed-length bursts, reads it back and reports mismatches.
module avl_burst_master_tg #(
  parameter int AVL_A_W   = 22,
  parameter int AVL_D_W   = 32,
  parameter int AVL_BE_W  = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                csi_clockreset_clk,
  input  logic                csi_clockreset_reset_n,
  input  logic                start,
  input  logic [AVL_A_W-1:0]  cfg_base_addr,
  input  logic [AVL_D_W-1:0]  cfg_seed,
  input  logic [7:0]          cfg_nbursts,
  output logic [AVL_A_W-1:0]  avm_m1_address,
  output logic                avm_m1_read,
  output logic                avm_m1_write,
  output logic                avm_m1_beginbursttransfer,
  input  logic                avm_m1_waitrequest,
  output logic [3:0]          avm_m1_burstcount,
  input  logic                avm_m1_readdatavalid,
  input  logic [AVL_D_W-1:0]  avm_m1_readdata,
  output logic [AVL_BE_W-1:0] avm_m1_byteenable,
  output logic [AVL_D_W-1:0]  avm_m1_writedata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_cnt,
  output logic [AVL_A_W-1:0]  first_err_addr
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_CMD  = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  logic [2:0]         r_state;
  logic [AVL_A_W-1:0] r_base;
  logic [AVL_D_W-1:0] r_seed;
  logic [7:0]         r_nb;
  logic [7:0]         r_b;
  logic [3:0]         r_k;
  logic               r_first;
  logic [15:0]        r_err;
  logic [AVL_A_W-1:0] r_ferr;
  logic               r_done;
  logic               r_pass;
  logic [31:0]        w_bofs;
  logic [31:0]        w_idx;
  logic [AVL_A_W-1:0] w_burst_addr;
  logic [AVL_D_W-1:0] w_exp;
  logic               w_last_beat;
  logic               w_last_burst;
  logic               w_mis;
  logic               w_spur;
  logic               w_err;
  logic [AVL_A_W-1:0] w_err_addr;
  assign w_bofs       = 32'(r_b) * 32'(BURST_LEN);
  assign w_idx        = w_bofs + 32'(r_k);
  assign w_burst_addr = r_base + AVL_A_W'(w_bofs);
  assign w_exp        = r_seed + AVL_D_W'(w_idx);
  assign w_last_beat  = r_k == 4'(BURST_LEN - 1);
  assign w_last_burst = r_b == r_nb - 8'd1;
  assign w_mis        = r_state == S_RD_DATA && avm_m1_readdatavalid && avm_m1_readdata != w_exp;
  // A beat arriving when no read burst is outstanding is charged to the current burst base.
  assign w_spur       = r_state != S_RD_DATA && avm_m1_readdatavalid;
  assign w_err        = w_mis || w_spur;
  assign w_err_addr   = w_mis ? r_base + AVL_A_W'(w_idx) : w_burst_addr;
  assign avm_m1_write              = r_state == S_WR;
  assign avm_m1_read               = r_state == S_RD_CMD;
  assign avm_m1_beginbursttransfer = r_first && (avm_m1_write || avm_m1_read);
  assign avm_m1_address            = (avm_m1_write || avm_m1_read) ? w_burst_addr : '0;
  assign avm_m1_burstcount         = (avm_m1_write || avm_m1_read) ? 4'(BURST_LEN) : 4'd0;
  assign avm_m1_byteenable         = avm_m1_write ? '1 : '0;
  assign avm_m1_writedata          = avm_m1_write ? w_exp : '0;
  assign busy           = r_state == S_WR || r_state == S_RD_CMD || r_state == S_RD_DATA;
  assign done           = r_done || r_state == S_DONE;
  assign pass           = r_state == S_DONE ? r_err == 16'd0 : r_pass;
  assign err_cnt        = r_err;
  assign first_err_addr = r_ferr;
  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
    if (!csi_clockreset_reset_n) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_seed  <= '0;
      r_nb    <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_first <= 1'b0;
      r_err   <= '0;
      r_ferr  <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_first <= 1'b0;
      if (w_err) begin
        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
        if (r_err == 16'd0) r_ferr <= w_err_addr;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_base  <= cfg_base_addr;
          r_seed  <= cfg_seed;
          r_nb    <= cfg_nbursts;
          r_b     <= '0;
          r_k     <= '0;
          r_err   <= '0;
          r_ferr  <= '0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
          r_first <= cfg_nbursts != 8'd0;
          r_state <= cfg_nbursts == 8'd0 ? S_DONE : S_WR;
        end
        S_WR: if (!avm_m1_waitrequest) begin
          r_k <= w_last_beat ? 4'd0 : r_k + 4'd1;
          if (w_last_beat) begin
            r_first <= 1'b1;
            r_b     <= w_last_burst ? 8'd0 : r_b + 8'd1;
            if (w_last_burst) r_state <= S_RD_CMD;
          end
        end
        S_RD_CMD: if (!avm_m1_waitrequest) begin
          r_k     <= 4'd0;
          r_state <= S_RD_DATA;
        end
        S_RD_DATA: if (avm_m1_readdatavalid) begin
          r_k <= w_last_beat ? 4'd0 : r_k + 4'd1;
          if (w_last_beat) begin
            r_b     <= r_b + 8'd1;
            r_first <= !w_last_burst;
            r_state <= w_last_burst ? S_DONE : S_RD_CMD;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_pass  <= r_err == 16'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
